// File: rtl/approx_error_monitor_if.sv
// Bundle between the adder-pair front end / readout logic and the error monitor.
// The front end drives samples and window control; the monitor returns handshake and statistics.
interface approx_error_monitor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = WIDTH + 1 + CNT_W
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   approx_res;
  logic [WIDTH:0]   exact_res;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] samples_seen;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] ed_sum;
  logic [WIDTH:0]   ed_max;

  modport master (
    output start, num_samples, in_valid, approx_res, exact_res,
    input  in_ready, busy, done, samples_seen, err_count, ed_sum, ed_max
  );

  modport slave (
    input  start, num_samples, in_valid, approx_res, exact_res,
    output in_ready, busy, done, samples_seen, err_count, ed_sum, ed_max
  );
endinterface

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate adder checked against the exact adder:
// error count, sum and maximum of the error distance over N accepted sample pairs.
module approx_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = WIDTH + 1 + CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  approx_error_monitor_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_seen;
  logic [CNT_W-1:0] r_errc;
  logic [ACC_W-1:0] r_sum;
  logic [WIDTH:0]   r_max;
  logic [WIDTH:0]   r_ed_p1;
  logic             r_vld_p1;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_last;

  // One extra bit of headroom keeps the full-scale distance 2^(WIDTH+1)-1 from wrapping.
  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic signed [WIDTH+1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d[WIDTH:0];
  endfunction

  assign w_accept   = bus.in_valid && (r_state == S_RUN);
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = w_accept && (r_seen == (r_num - CNT_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = (bus.num_samples == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_vld_p1) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_num    <= '0;
      r_seen   <= '0;
      r_errc   <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_ed_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // S1: error distance of the accepted pair
      r_vld_p1 <= w_accept;
      if (w_accept) r_ed_p1 <= abs_diff(bus.approx_res, bus.exact_res);
      // S2: fold the distance into the window statistics
      if (w_start_ok) begin
        r_num  <= bus.num_samples;
        r_seen <= '0;
        r_errc <= '0;
        r_sum  <= '0;
        r_max  <= '0;
      end else begin
        if (w_accept) r_seen <= r_seen + CNT_W'(1);
        if (r_vld_p1) begin
          r_sum  <= r_sum + ACC_W'(r_ed_p1);
          r_errc <= r_errc + CNT_W'(r_ed_p1 != '0);
          if (r_ed_p1 > r_max) r_max <= r_ed_p1;
        end
      end
    end
  end

  assign bus.in_ready     = (r_state == S_RUN);
  assign bus.busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done         = (r_state == S_DONE);
  assign bus.samples_seen = r_seen;
  assign bus.err_count    = r_errc;
  assign bus.ed_sum       = r_sum;
  assign bus.ed_max       = r_max;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomised and directed stimulus for approx_error_monitor; a driver-side window model
// queues expected statistics and a negedge monitor compares them when done rises.
module tb_approx_error_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int ACC_W = WIDTH + 1 + CNT_W;
  localparam int MAXV  = (1 << (WIDTH + 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_error_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  approx_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int     done_at;
    int     seen;
    int     errc;
    longint sum;
    int     max;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_tot   = 0;
  int   neg_cnt = 0;
  bit   exp_chk = 0;
  bit   exp_ready = 0;
  bit   chk_rst = 1;
  bit   fin_chk = 0;

  // window model: plain arithmetic over the accepted pairs
  bit     m_run = 0;
  int     m_n, m_cnt, m_errc, m_max;
  longint m_sum;

  task automatic check(input string nm, input longint act, input longint req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  task automatic push_exp(input int at);
    exp_t e;
    e.done_at = at; e.seen = m_cnt; e.errc = m_errc; e.sum = m_sum; e.max = m_max;
    sbq.push_back(e);
  endtask

  // Called at posedge+1; drives one cycle and advances the model at the following edge.
  task automatic step(input bit st, input int n, input bit v, input int a, input int e);
    int k;
    int d;
    bus.start       = st;
    bus.num_samples = n[CNT_W-1:0];
    bus.in_valid    = v;
    bus.approx_res  = a[WIDTH:0];
    bus.exact_res   = e[WIDTH:0];
    exp_ready = m_run;
    exp_chk   = 1;
    k = neg_cnt;
    @(posedge clk);
    if (st && !m_run) begin
      m_n = n; m_cnt = 0; m_errc = 0; m_sum = 0; m_max = 0;
      m_run = (n > 0);
      if (n == 0) push_exp(k + 2);
    end else if (v && m_run) begin
      d = a - e;
      if (d < 0) d = -d;
      m_cnt++;
      if (d != 0) m_errc++;
      m_sum += d;
      if (d > m_max) m_max = d;
      if (m_cnt == m_n) begin
        m_run = 0;
        push_exp(k + 4);
      end
    end
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1; chk_rst = 1; exp_chk = 0; m_run = 0;
    bus.start = 0; bus.in_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; chk_rst = 0;
  endtask

  // monitor / scoreboard
  initial begin
    bit   prev_done;
    exp_t e;
    prev_done = 0;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (chk_rst) begin
        check("rst_samples_seen", bus.samples_seen, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_ed_sum", bus.ed_sum, 0);
        check("rst_ed_max", bus.ed_max, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
      end
      if (exp_chk) check("in_ready", bus.in_ready, exp_ready);
      if (bus.done && !prev_done) begin
        if (sbq.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_done: done rose with no window outstanding (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("done_latency", neg_cnt, e.done_at);
          check("samples_seen", bus.samples_seen, e.seen);
          check("err_count", bus.err_count, e.errc);
          check("ed_sum", bus.ed_sum, e.sum);
          check("ed_max", bus.ed_max, e.max);
          check("busy_in_done", bus.busy, 0);
        end
      end else if (sbq.size() > 0 && neg_cnt > sbq[0].done_at) begin
        n_tot++;
        $display("FAIL done_timeout: done absent at cycle %0d, required by %0d", neg_cnt, sbq[0].done_at);
        void'(sbq.pop_front());
      end
      if (fin_chk) check("scoreboard_empty", sbq.size(), 0);
      prev_done = bus.done;
    end
  end

  // driver
  initial begin
    int n, a, e, guard, mode;
    bit v;
    bus.start = 0; bus.num_samples = '0; bus.in_valid = 0;
    bus.approx_res = '0; bus.exact_res = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; chk_rst = 0;

    // reset mid-RUN after 3 accepts
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 100, 90);
    step(0, 0, 1, 7, 20);
    step(0, 0, 1, 500, 499);
    do_reset();

    // empty window
    step(1, 0, 0, 0, 0);
    idle(3);

    // directed four-sample window
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 371, 375);
    step(0, 0, 1, 322, 322);
    step(0, 0, 1, 80, 78);
    step(0, 0, 1, 11, 11);
    idle(4);

    // gap in valid and a start that must be ignored
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1000, 1234);
    step(1, 7, 0, 5, 9);
    step(0, 0, 1, 42, 40);
    idle(4);

    // full-scale distance
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, MAXV, 0);
    idle(4);

    // restart from DONE with an exact pair
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 375, 375);
    idle(4);

    // randomised windows
    for (int w = 0; w < 10; w++) begin
      n = $urandom_range(1, 6);
      step(1, n, $urandom_range(0, 1), $urandom_range(0, MAXV), $urandom_range(0, MAXV));
      guard = 0;
      while (m_run && guard < 100) begin
        v = ($urandom_range(0, 3) != 0);
        a = $urandom_range(0, MAXV);
        mode = $urandom_range(0, 3);
        if (mode == 0) e = a;
        else if (mode == 1) begin
          e = a + $urandom_range(0, 8) - 4;
          if (e < 0) e = 0;
          if (e > MAXV) e = MAXV;
        end else if (mode == 2) e = (a > MAXV / 2) ? 0 : MAXV;
        else e = $urandom_range(0, MAXV);
        step(0, 0, v, a, e);
        guard++;
      end
      idle(4);
    end

    fin_chk = 1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
